// File: rtl/tt_pad_pkg.sv
// Shared constants and helpers for the pad input deglitch filter.
// The TT_PAD_EDGE_EN macro enables the rise/fall pulse outputs in the RTL that imports this package.
package tt_pad_pkg;

    localparam int DEF_WIDTH    = 6;
    localparam int DEF_FILT_LEN = 4;

    // Per-bit decision taken on every clock edge.
    typedef enum logic [1:0] {
        ACT_CLEAR  = 2'd0,
        ACT_COUNT  = 2'd1,
        ACT_UPDATE = 2'd2
    } filt_act_e;

    function automatic int cnt_width(input int filt_len);
        return $clog2(filt_len) + 1;
    endfunction

endpackage

// File: rtl/tt_pad_filt_bit.sv
// One pad bit: 2-flop synchronizer followed by a stability counter.
// Defining TT_PAD_EDGE_EN adds registered rise/fall pulses aligned with the filtered level change.
module tt_pad_filt_bit
    import tt_pad_pkg::*;
#(
    parameter int   FILT_LEN  = DEF_FILT_LEN,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    output logic filt_out
`ifdef TT_PAD_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int            CW       = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    filt_act_e     w_act;

    // NOTE: non-blocking assignments keep s1 and s2 as two distinct flops; blocking would collapse them into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RESET_BIT;
            r_s2 <= RESET_BIT;
        end else begin
            r_s1 <= pad_in;
            r_s2 <= r_s1;
        end
    end

    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        w_act = ACT_CLEAR;
        if (r_s2 != r_filt) begin
            w_act = (r_cnt == CNT_LAST) ? ACT_UPDATE : ACT_COUNT;
        end
    end

    // Counting only happens below CNT_LAST, so the counter can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= RESET_BIT;
        end else begin
            case (w_act)
                ACT_COUNT:  r_cnt <= r_cnt + CW'(1);
                ACT_UPDATE: begin
                    r_cnt  <= '0;
                    r_filt <= r_s2;
                end
                default:    r_cnt <= '0;
            endcase
        end
    end

    assign filt_out = r_filt;

`ifdef TT_PAD_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses load on the same edge as r_filt, so they line up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (w_act == ACT_UPDATE) &&  r_s2;
            r_fall <= (w_act == ACT_UPDATE) && !r_s2;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule

// File: rtl/tt_pad_in_filter.sv
// Synchronizes and deglitches WIDTH asynchronous pad inputs, one tt_pad_filt_bit per bit.
// Defining TT_PAD_EDGE_EN adds the rise/fall pulse outputs.
module tt_pad_in_filter
    import tt_pad_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               FILT_LEN  = DEF_FILT_LEN,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] filt_out
`ifdef TT_PAD_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tt_pad_filt_bit #(
            .FILT_LEN  (FILT_LEN),
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad_in   (pad_in[i]),
            .filt_out (filt_out[i])
`ifdef TT_PAD_EDGE_EN
            ,
            .rise     (rise[i]),
            .fall     (fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_tt_pad_in_filter.sv
// Directed bench: FILT_LEN=4 instance checked against hand-computed vectors, FILT_LEN=1 instance
// (RESET_VAL=6'h2A) checked against a two-edge delay model driven by the same pad stimulus.
module tb_tt_pad_in_filter;

    localparam int          W   = 6;
    localparam logic [W-1:0] RV1 = 6'h2A;

    typedef struct {
        logic [W-1:0] pad;
        logic [W-1:0] filt;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        int           reps;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] pad_in = '0;
    logic [W-1:0] filt4;
    logic [W-1:0] filt1;
`ifdef TT_PAD_EDGE_EN
    logic [W-1:0] rise4, fall4, rise1, fall1;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model of the FILT_LEN=1 instance: pad two steps back, previous filtered value.
    logic [W-1:0] h1, h2, h3;

    tt_pad_in_filter #(.WIDTH(W), .FILT_LEN(4), .RESET_VAL('0)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .pad_in   (pad_in),
        .filt_out (filt4)
`ifdef TT_PAD_EDGE_EN
        ,
        .rise     (rise4),
        .fall     (fall4)
`endif
    );

    tt_pad_in_filter #(.WIDTH(W), .FILT_LEN(1), .RESET_VAL(RV1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .pad_in   (pad_in),
        .filt_out (filt1)
`ifdef TT_PAD_EDGE_EN
        ,
        .rise     (rise1),
        .fall     (fall1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; drives pad, samples 1 time unit after the next rising edge.
    task automatic step(input vec_t v);
        pad_in = v.pad;
        @(posedge clk);
        #1;
        check({v.name, " filt4"}, filt4, v.filt);
        check({v.name, " filt1"}, filt1, h2);
`ifdef TT_PAD_EDGE_EN
        check({v.name, " rise4"}, rise4, v.rise);
        check({v.name, " fall4"}, fall4, v.fall);
        check({v.name, " rise1"}, rise1, h2 & ~h3);
        check({v.name, " fall1"}, fall1, ~h2 & h3);
`endif
        h3 = h2;
        h2 = h1;
        h1 = v.pad;
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [W-1:0] p);
        pad_in = p;
        rst_n  = 1'b0;
        #1;
        check("reset filt4", filt4, '0);
        check("reset filt1", filt1, RV1);
`ifdef TT_PAD_EDGE_EN
        check("reset rise4", rise4, '0);
        check("reset fall4", fall4, '0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        h1 = RV1;
        h2 = RV1;
        h3 = RV1;
    endtask

    // Pad held at p through release: level appears on the 6th edge after release, pulse with it.
    task automatic release_seq(input string tag, input logic [W-1:0] p);
        vec_t v;
        for (int k = 1; k <= 8; k++) begin
            v.pad  = p;
            v.filt = (k >= 6) ? p : '0;
            v.rise = (k == 6) ? p : '0;
            v.fall = '0;
            v.reps = 1;
            v.name = $sformatf("%s edge%0d", tag, k);
            step(v);
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;

        tbl.push_back('{6'h01, 6'h00, 6'h00, 6'h00, 5, "b0 rise wait"});
        tbl.push_back('{6'h01, 6'h01, 6'h01, 6'h00, 1, "b0 rise"});
        tbl.push_back('{6'h01, 6'h01, 6'h00, 6'h00, 1, "b0 rise done"});
        tbl.push_back('{6'h05, 6'h01, 6'h00, 6'h00, 3, "b2 3cyc pulse"});
        tbl.push_back('{6'h01, 6'h01, 6'h00, 6'h00, 5, "b2 rejected"});
        tbl.push_back('{6'h00, 6'h01, 6'h00, 6'h00, 5, "b0 fall wait"});
        tbl.push_back('{6'h00, 6'h00, 6'h00, 6'h01, 1, "b0 fall"});
        tbl.push_back('{6'h00, 6'h00, 6'h00, 6'h00, 1, "b0 fall done"});
        tbl.push_back('{6'h08, 6'h00, 6'h00, 6'h00, 4, "b3 4cyc pulse"});
        tbl.push_back('{6'h00, 6'h00, 6'h00, 6'h00, 1, "b3 wait"});
        tbl.push_back('{6'h00, 6'h08, 6'h08, 6'h00, 1, "b3 rise"});
        tbl.push_back('{6'h00, 6'h08, 6'h00, 6'h00, 3, "b3 high"});
        tbl.push_back('{6'h00, 6'h00, 6'h00, 6'h08, 1, "b3 fall"});
        tbl.push_back('{6'h00, 6'h00, 6'h00, 6'h00, 1, "b3 done"});

        @(negedge clk);

        // Reset with all pads high, then release.
        apply_reset(6'h3F);
        release_seq("rel3F", 6'h3F);

        // Clean reset with pads low and settle.
        apply_reset(6'h00);
        for (int k = 0; k < 6; k++) begin
            step('{6'h00, 6'h00, 6'h00, 6'h00, 1, "settle"});
        end

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i]);
            end
        end

        // Bits 1 and 4 rise together; bit 4 glitches low for one cycle mid-count.
        for (int k = 0; k < 10; k++) begin
            v.pad  = (k == 2) ? 6'h02 : 6'h12;
            v.filt = (k >= 8) ? 6'h12 : (k >= 5) ? 6'h02 : 6'h00;
            v.rise = (k == 8) ? 6'h10 : (k == 5) ? 6'h02 : 6'h00;
            v.fall = '0;
            v.reps = 1;
            v.name = $sformatf("b1b4 step%0d", k);
            step(v);
        end

        // Bit 0 counting (counter reaches 2), reset asserted mid-count, full delay after release.
        for (int k = 0; k < 4; k++) begin
            step('{6'h13, 6'h12, 6'h00, 6'h00, 1, "b0 midcount"});
        end
        apply_reset(6'h13);
        release_seq("relmid", 6'h13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
